mesi_cbus_agent: RTL and testbench
==================================

MESI_CBUS_AGENT -- requirements
Module: mesi_cbus_agent

Parameters
REQ-001 ADDR_WIDTH, default 32: address width on cbus and writeback ports.
REQ-002 IDX_WIDTH, default 2: line index width; table holds 2**IDX_WIDTH direct-mapped lines.
REQ-003 WB_CYCLES, default 4 (legal 1..15): cycles spent in writeback per Modified-line eviction.

Interface
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cbus_cmd_i  input  3  coherence command from the intersection controller: 0 NOP, 1 WR_SNOOP, 2 RD_SNOOP, 3 EN_WR, 4 EN_RD, 5-7 reserved.
REQ-007 cbus_addr_i  input  ADDR_WIDTH  line address for cbus_cmd_i.
REQ-008 cbus_ack_o  output  1  single-cycle completion pulse back to the controller.
REQ-009 wb_req_o  output  1  high while a Modified line is being written back.
REQ-010 wb_addr_o  output  ADDR_WIDTH  captured address of the line being written back.
REQ-011 probe_addr_i  input  ADDR_WIDTH  debug lookup address.
REQ-012 probe_state_o  output  2  combinational MESI state of probe_addr_i: 0 I, 1 S, 2 E, 3 M; 0 on tag mismatch.

Function
REQ-013 Index = addr[IDX_WIDTH-1:0]; tag = addr[ADDR_WIDTH-1:IDX_WIDTH]; each line stores tag and 2-bit MESI state.
REQ-014 Hit = stored tag equals tag and state != I; a miss is treated as state I.
REQ-015 FSM states: IDLE, EXEC, WB, ACK, WAIT_NOP.
REQ-016 IDLE: cbus_cmd_i != NOP captures cmd and addr, moves to EXEC; NOP stays in IDLE.
REQ-017 EXEC: WR_SNOOP or RD_SNOOP hitting an M line goes to WB; all other cases apply the state update and go to ACK.
REQ-018 WB: wb_req_o = 1 and wb_addr_o = captured addr for exactly WB_CYCLES cycles (4-bit down-counter); on the last cycle apply the state update, then go to ACK.
REQ-019 State updates: WR_SNOOP hit -> I; RD_SNOOP hit (M or E) -> S; RD_SNOOP hit (S) -> unchanged; snoop miss -> no change.
REQ-020 EN_WR installs tag, state M; EN_RD installs tag, state S; either overwrites a non-M victim at that index without writeback.
REQ-021 EN_WR/EN_RD to an index holding an M line with a different tag first goes through WB with wb_addr_o = {victim tag, index}, then installs.
REQ-022 Reserved commands 5-7: no table change, no WB; normal ack.
REQ-023 ACK: cbus_ack_o = 1 for exactly one cycle, then WAIT_NOP.
REQ-024 WAIT_NOP: ignore cbus_cmd_i until it is NOP, then IDLE; a held command is never re-executed.
REQ-025 Latency: command sampled in IDLE at cycle N gives ack at cycle N+2 without writeback and N+2+WB_CYCLES with writeback.
REQ-026 cbus_cmd_i/cbus_addr_i changes after capture are ignored until WAIT_NOP exits.
REQ-027 probe_state_o is purely combinational and reflects table updates from the cycle after they are written.

Reset
REQ-028 rst = 1 at a rising edge: FSM -> IDLE, all line states -> I, counter -> 0, cbus_ack_o = 0, wb_req_o = 0, wb_addr_o = 0.
REQ-029 Reset during WB or ACK aborts the operation: no ack and no table update are produced for it.
REQ-030 First command is sampled on the first rising edge with rst = 0.

Verification
REQ-031 EN_WR 0x40 held from cycle N -> ack at N+2; probe 0x40 = M; cmd still held in WAIT_NOP -> no second ack.
REQ-032 Line 0x40 in M, RD_SNOOP 0x40 -> wb_req_o high 4 cycles with wb_addr_o = 0x40, ack at N+6, probe 0x40 = S.
REQ-033 Line 0x40 in S, WR_SNOOP 0x44 (same index, other tag) -> ack at N+2, no wb_req_o, probe 0x40 still S.
REQ-034 Line 0x40 in M, EN_RD 0x80 -> writeback of 0x40 for 4 cycles, ack at N+6, probe 0x80 = S, probe 0x40 = I.
REQ-035 rst asserted on 2nd WB cycle of a RD_SNOOP -> wb_req_o and cbus_ack_o low next cycle, all probes I, no ack ever issued.
REQ-036 cmd = 6 -> ack at N+2, table unchanged, wb_req_o stays 0.

Source files
------------

// File: rtl/mesi_cbus_agent.sv
// Coherence-bus agent: a direct-mapped MESI tag/state table driven by intersection-controller
// commands, with a fixed-length writeback whenever a Modified line is snooped or evicted.
module mesi_cbus_agent #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 2,
  parameter int WB_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0] cbus_addr_i,
  output logic                  cbus_ack_o,
  output logic                  wb_req_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  input  logic [ADDR_WIDTH-1:0] probe_addr_i,
  output logic [1:0]            probe_state_o
);
  localparam int         LINES   = 1 << IDX_WIDTH;
  localparam int         TAG_W   = ADDR_WIDTH - IDX_WIDTH;
  localparam logic [3:0] WB_LOAD = 4'(WB_CYCLES - 1);

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CMD_EN_RD    = 3'd4;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_M = 2'd3;

  // IDLE wait cmd | EXEC lookup | WB write back M line | ACK pulse | WAIT_NOP wait for cmd release
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WB, S_ACK, S_WAIT_NOP} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [TAG_W-1:0]      tag_q [LINES];
  logic [1:0]            st_q  [LINES];

  logic [IDX_WIDTH-1:0]  idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            cur_st;
  logic                  hit;
  logic                  is_snoop;
  logic                  is_en;
  logic                  need_wb;
  logic                  upd_en;
  logic [1:0]            new_st;
  logic [TAG_W-1:0]      new_tag;
  logic [IDX_WIDTH-1:0]  p_idx;

  assign idx      = addr_q[IDX_WIDTH-1:0];
  assign tag      = addr_q[ADDR_WIDTH-1:IDX_WIDTH];
  assign cur_st   = st_q[idx];
  assign hit      = (tag_q[idx] == tag) && (cur_st != ST_I);
  assign is_snoop = (cmd_q == CMD_WR_SNOOP) || (cmd_q == CMD_RD_SNOOP);
  assign is_en    = (cmd_q == CMD_EN_WR) || (cmd_q == CMD_EN_RD);
  // A snoop hit on M and an eviction of an M victim both write back the resident line.
  assign need_wb  = (cur_st == ST_M) && ((is_snoop && hit) || (is_en && (tag_q[idx] != tag)));

  always_comb begin
    new_tag = tag_q[idx];
    new_st  = cur_st;
    case (cmd_q)
      CMD_WR_SNOOP: if (hit) new_st = ST_I;
      CMD_RD_SNOOP: if (hit) new_st = ST_S;
      CMD_EN_WR: begin
        new_tag = tag;
        new_st  = ST_M;
      end
      CMD_EN_RD: begin
        new_tag = tag;
        new_st  = ST_S;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wb_addr_d = wb_addr_q;
    cnt_d     = cnt_q;
    upd_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cbus_cmd_i != CMD_NOP) begin
          cmd_d   = cbus_cmd_i;
          addr_d  = cbus_addr_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (need_wb) begin
          wb_addr_d = {tag_q[idx], idx};
          cnt_d     = WB_LOAD;
          state_d   = S_WB;
        end else begin
          upd_en  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_WB: begin
        if (cnt_q == 4'd0) begin
          upd_en  = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:      state_d = S_WAIT_NOP;
      S_WAIT_NOP: if (cbus_cmd_i == CMD_NOP) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      wb_addr_q <= '0;
      cnt_q     <= 4'd0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
        st_q[i]  <= ST_I;
      end
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wb_addr_q <= wb_addr_d;
      cnt_q     <= cnt_d;
      if (upd_en) begin
        tag_q[idx] <= new_tag;
        st_q[idx]  <= new_st;
      end
    end
  end

  assign cbus_ack_o = (state_q == S_ACK);
  assign wb_req_o   = (state_q == S_WB);
  assign wb_addr_o  = wb_addr_q;

  assign p_idx         = probe_addr_i[IDX_WIDTH-1:0];
  assign probe_state_o = (tag_q[p_idx] == probe_addr_i[ADDR_WIDTH-1:IDX_WIDTH]) ? st_q[p_idx] : ST_I;

endmodule

// File: tb/tb_mesi_cbus_agent.sv
// Bench for mesi_cbus_agent: directed and random commands compared against a
// line-address cache model; checks latency, ack count, writeback and probe state.
module tb_mesi_cbus_agent;
  localparam int AW  = 32;
  localparam int IW  = 2;
  localparam int WBC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    cbus_cmd_i;
  logic [AW-1:0] cbus_addr_i;
  logic          cbus_ack_o;
  logic          wb_req_o;
  logic [AW-1:0] wb_addr_o;
  logic [AW-1:0] probe_addr_i;
  logic [1:0]    probe_state_o;

  int ncmp = 0;
  int nerr = 0;

  // Model: one resident full line address and its MESI state per index.
  logic [31:0] res_addr [4];
  int          res_st   [4];

  always #5 clk = ~clk;

  mesi_cbus_agent #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW), .WB_CYCLES(WBC)) dut (
    .clk          (clk),
    .rst          (rst),
    .cbus_cmd_i   (cbus_cmd_i),
    .cbus_addr_i  (cbus_addr_i),
    .cbus_ack_o   (cbus_ack_o),
    .wb_req_o     (wb_req_o),
    .wb_addr_o    (wb_addr_o),
    .probe_addr_i (probe_addr_i),
    .probe_state_o(probe_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mdl_probe(input logic [31:0] a);
    int i;
    i = int'(a[1:0]);
    return (res_st[i] != 0 && res_addr[i] == a) ? res_st[i] : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      res_addr[i] = 32'h0;
      res_st[i]   = 0;
    end
  endtask

  task automatic check_probe(input string tag, input logic [31:0] a);
    probe_addr_i = a;
    #1;
    chk(tag, 32'(probe_state_o), 32'(mdl_probe(a)));
  endtask

  // Called at a negedge with the agent idle; returns at a negedge with it idle again.
  task automatic do_cmd(input logic [2:0] cmd, input logic [31:0] addr);
    int          i;
    bit          hit;
    bit          exp_wb;
    logic [31:0] exp_wba;
    logic [31:0] first_wba;
    int          exp_ack;
    int          ack_cyc;
    int          acks;
    int          wbs;
    int          wbbad;
    i       = int'(addr[1:0]);
    hit     = (res_st[i] != 0) && (res_addr[i] == addr);
    exp_wb  = ((cmd == 3'd1 || cmd == 3'd2) && hit && res_st[i] == 3) ||
              ((cmd == 3'd3 || cmd == 3'd4) && res_st[i] == 3 && res_addr[i] != addr);
    exp_wba = res_addr[i];
    exp_ack = exp_wb ? 1 + WBC : 1;
    cbus_cmd_i  = cmd;
    cbus_addr_i = addr;
    ack_cyc   = -1;
    acks      = 0;
    wbs       = 0;
    wbbad     = 0;
    first_wba = 32'hdead_beef;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      cbus_addr_i = 32'($urandom_range(0, 255));
      if (cbus_ack_o) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = c;
      end
      if (wb_req_o) begin
        if (wbs == 0) first_wba = wb_addr_o;
        wbs++;
        if (wb_addr_o !== exp_wba) wbbad++;
      end
    end
    case (cmd)
      3'd1: if (hit) res_st[i] = 0;
      3'd2: if (hit) res_st[i] = 1;
      3'd3: begin res_addr[i] = addr; res_st[i] = 3; end
      3'd4: begin res_addr[i] = addr; res_st[i] = 1; end
      default: ;
    endcase
    chk("ack_latency", 32'(ack_cyc), 32'(exp_ack));
    chk("ack_count", 32'(acks), 32'd1);
    chk("wb_cycles", 32'(wbs), exp_wb ? 32'(WBC) : 32'd0);
    chk("wb_addr_stable", 32'(wbbad), 32'd0);
    if (exp_wb) chk("wb_addr", first_wba, exp_wba);
    cbus_cmd_i = 3'd0;
    @(negedge clk);
    check_probe("probe_cmd_line", addr);
    check_probe("probe_victim_line", exp_wba);
  endtask

  initial begin
    int late_acks;
    rst          = 1'b1;
    cbus_cmd_i   = 3'd0;
    cbus_addr_i  = '0;
    probe_addr_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(cbus_ack_o), 32'd0);
    chk("reset_wb_req", 32'(wb_req_o), 32'd0);
    chk("reset_wb_addr", wb_addr_o, 32'd0);
    check_probe("reset_probe_0x40", 32'h40);

    // First command issued on the very first edge out of reset.
    rst = 1'b0;
    do_cmd(3'd3, 32'h40);
    check_probe("en_wr_probe_m", 32'h40);
    do_cmd(3'd2, 32'h40);
    do_cmd(3'd1, 32'h44);
    check_probe("snoop_miss_keeps_s", 32'h40);
    do_cmd(3'd3, 32'h40);
    do_cmd(3'd4, 32'h80);
    check_probe("evict_new_s", 32'h80);
    check_probe("evict_old_i", 32'h40);
    do_cmd(3'd6, 32'h80);
    check_probe("reserved_unchanged", 32'h80);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = (n % 3 == 0) ? 32'($urandom_range(0, 3)) << 6 : 32'($urandom_range(0, 15));
      do_cmd(3'($urandom_range(1, 7)), a);
      check_probe("rand_probe", 32'($urandom_range(0, 15)));
    end

    // Reset in the second writeback cycle of a RD_SNOOP hit on M.
    do_cmd(3'd3, 32'h40);
    cbus_cmd_i  = 3'd2;
    cbus_addr_i = 32'h40;
    @(negedge clk);
    @(negedge clk);
    chk("wb_before_reset", 32'(wb_req_o), 32'd1);
    @(negedge clk);
    rst        = 1'b1;
    cbus_cmd_i = 3'd0;
    @(negedge clk);
    model_reset();
    chk("abort_wb_req", 32'(wb_req_o), 32'd0);
    chk("abort_ack", 32'(cbus_ack_o), 32'd0);
    chk("abort_wb_addr", wb_addr_o, 32'd0);
    rst = 1'b0;
    check_probe("abort_probe_0x40", 32'h40);
    check_probe("abort_probe_0x80", 32'h80);
    for (int k = 0; k < 16; k++) check_probe("abort_probe_low", 32'(k));
    late_acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cbus_ack_o) late_acks++;
    end
    chk("abort_no_ack", 32'(late_acks), 32'd0);
    do_cmd(3'd4, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
